// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: steps one Mac through an N_IN x M_OUT fully-connected layer.
// Define RELU_EN to clamp negative neuron sums to zero when they are captured.
module mac_layer_sequencer #(
    parameter int N_IN  = 4,
    parameter int M_OUT = 4,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   x_addr,
    output logic [AW-1:0]   w_addr,
    input  logic [DW-1:0]   x_data,
    input  logic [DW-1:0]   w_data,
    output logic            mac_clr,
    output logic [DW-1:0]   mac_a,
    output logic [DW-1:0]   mac_b,
    output logic            mac_valid_in,
    input  logic [2*DW-1:0] mac_f,
    input  logic            mac_valid_out,
    output logic [2*DW-1:0] y_data,
    output logic [AW-1:0]   y_addr,
    output logic            y_valid,
    input  logic            y_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] N_LAST = AW'(N_IN - 1);
    localparam logic [AW-1:0] M_LAST = AW'(M_OUT - 1);
    localparam logic [AW-1:0] N_STEP = AW'(N_IN);

    state_t          state_q, state_d;
    logic [AW-1:0]   m_q, m_d;
    logic [AW-1:0]   n_q, n_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   xa_q, xa_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            vin_q, vin_d;
    logic [2*DW-1:0] y_q, y_d;
    logic [AW-1:0]   ya_q, ya_d;
    logic            yv_q, yv_d;
    logic [2*DW-1:0] sum_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            xa_q    <= '0;
            wa_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vin_q   <= 1'b0;
            y_q     <= '0;
            ya_q    <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            xa_q    <= xa_d;
            wa_q    <= wa_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vin_q   <= vin_d;
            y_q     <= y_d;
            ya_q    <= ya_d;
            yv_q    <= yv_d;
        end
    end

`ifdef RELU_EN
    assign sum_c = mac_f[2*DW-1] ? '0 : mac_f;
`else
    assign sum_c = mac_f;
`endif

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        xa_d    = xa_q;
        wa_d    = wa_q;
        a_d     = a_q;
        b_d     = b_q;
        vin_d   = (state_q == S_FEED);
        y_d     = y_q;
        ya_d    = ya_q;
        yv_d    = yv_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = '0;
                    n_d     = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                n_d     = '0;
                cnt_d   = '0;
                xa_d    = '0;
                wa_d    = m_q * N_STEP;
                state_d = S_FEED;
            end
            S_FEED: begin
                // RAM data for the address on the bus is registered as the operand pair
                a_d = x_data;
                b_d = w_data;
                if (mac_valid_out) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (n_q == N_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    n_d  = n_q + 1'b1;
                    xa_d = n_q + 1'b1;
                    wa_d = wa_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (mac_valid_out) begin
                    if (cnt_q == N_LAST) begin
                        y_d     = sum_c;
                        ya_d    = m_q;
                        yv_d    = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (y_ready) begin
                    yv_d = 1'b0;
                    if (m_q == M_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        m_d     = m_q + 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mac is held cleared while this block is in reset
    assign mac_clr      = ~reset | (state_q == S_CLEAR);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign x_addr       = xa_q;
    assign w_addr       = wa_q;
    assign mac_a        = a_q;
    assign mac_b        = b_q;
    assign mac_valid_in = vin_q;
    assign y_data       = y_q;
    assign y_addr       = ya_q;
    assign y_valid      = yv_q;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer with a behavioural RAM and 2-stage Mac.
// Expected results are hand-computed for N_IN=4, M_OUT=2.
module tb_mac_layer_sequencer;

    localparam int N_IN  = 4;
    localparam int M_OUT = 2;
    localparam int DW    = 8;
    localparam int AW    = 8;

`ifdef RELU_EN
    localparam int E_R1_Y1 = 0;
    localparam int E_R3_Y0 = 0;
`else
    localparam int E_R1_Y1 = -10;
    localparam int E_R3_Y0 = -1020;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   x_addr;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   x_data;
    logic [DW-1:0]   w_data;
    logic            mac_clr;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic            mac_valid_in;
    logic [2*DW-1:0] mac_f;
    logic            mac_valid_out;
    logic [2*DW-1:0] y_data;
    logic [AW-1:0]   y_addr;
    logic            y_valid;
    logic            y_ready;

    mac_layer_sequencer #(
        .N_IN (N_IN),
        .M_OUT(M_OUT),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .x_addr       (x_addr),
        .w_addr       (w_addr),
        .x_data       (x_data),
        .w_data       (w_data),
        .mac_clr      (mac_clr),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_valid_in (mac_valid_in),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out),
        .y_data       (y_data),
        .y_addr       (y_addr),
        .y_valid      (y_valid),
        .y_ready      (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [DW-1:0] xm [256];
    logic signed [DW-1:0] wm [256];
    assign x_data = xm[x_addr];
    assign w_data = wm[w_addr];

    logic signed [2*DW-1:0] acc;
    logic signed [2*DW-1:0] prod;
    logic                   v1;
    logic                   v2;
    always @(posedge clk) begin
        if (mac_clr) begin
            acc  <= '0;
            prod <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            v1   <= mac_valid_in;
            prod <= $signed(mac_a) * $signed(mac_b);
            v2   <= v1;
            if (v1) acc <= acc + prod;
        end
    end
    assign mac_f         = acc;
    assign mac_valid_out = v2;

    int cyc = 0;
    logic [AW-1:0] w_prev;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        w_prev <= w_addr;
    end

    int vin_cyc[$];
    int waddr_q[$];
    int ys[$];
    int yas[$];
    int done_cnt = 0;
    int yfirst = -1;
    always @(negedge clk) begin
        if (mac_valid_in) begin
            vin_cyc.push_back(cyc);
            waddr_q.push_back(int'(w_prev));
        end
        if (y_valid && yfirst < 0) yfirst = cyc;
        if (y_valid && y_ready) begin
            ys.push_back(int'($signed(y_data)));
            yas.push_back(int'(y_addr));
        end
        if (done) done_cnt++;
    end

    int total = 0;
    int bad = 0;
    int base = 0;

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        vin_cyc.delete();
        waddr_q.delete();
        ys.delete();
        yas.delete();
        done_cnt = 0;
        yfirst   = -1;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (done_cnt == 0 && k < lim) begin
            tick(1);
            k++;
        end
        chk("done_seen", int'(done_cnt != 0), 1);
    endtask

    task automatic load(input int xv, input int w0, input int w1);
        for (int i = 0; i < N_IN; i++) begin
            xm[i]        = DW'(xv);
            wm[i]        = DW'(w0);
            wm[N_IN + i] = DW'(w1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        base  = cyc;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            xm[i] = '0;
            wm[i] = '0;
        end
        reset   = 1'b0;
        start   = 1'b0;
        y_ready = 1'b1;
        tick(3);

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_yvalid", int'(y_valid), 0);
        chk("rst_ydata", int'(y_data), 0);
        chk("rst_macclr", int'(mac_clr), 1);
        chk("rst_vin", int'(mac_valid_in), 0);
        chk("rst_waddr", int'(w_addr), 0);
        reset = 1'b1;
        tick(1);
        chk("idle_macclr", int'(mac_clr), 0);

        // Run 1: basic layer and cycle timing
        for (int i = 0; i < N_IN; i++) begin
            xm[i]        = DW'(i + 1);
            wm[i]        = 8'sd1;
            wm[N_IN + i] = -8'sd1;
        end
        clear_mon();
        pulse_start();
        chk("r1_clear_clr", int'(mac_clr), 1);
        chk("r1_clear_busy", int'(busy), 1);
        tick(1);
        chk("r1_feed_clr", int'(mac_clr), 0);
        chk("r1_feed_xaddr", int'(x_addr), 0);
        chk("r1_feed_vin", int'(mac_valid_in), 0);
        tick(1);
        chk("r1_vin3", int'(mac_valid_in), 1);
        chk("r1_mac_a", int'($signed(mac_a)), 1);
        chk("r1_mac_b", int'($signed(mac_b)), 1);
        wait_done(100);
        chk("r1_vin_n", vin_cyc.size(), 2 * N_IN);
        chk("r1_vin_first", vin_cyc[0] - base, 3);
        chk("r1_vin_last", vin_cyc[3] - base, 6);
        chk("r1_yvalid_cyc", yfirst - base, 9);
        chk("r1_ny", ys.size(), 2);
        chk("r1_y0", ys[0], 10);
        chk("r1_a0", yas[0], 0);
        chk("r1_y1", ys[1], E_R1_Y1);
        chk("r1_a1", yas[1], 1);
        for (int i = 0; i < 2 * N_IN; i++) begin
            chk($sformatf("r1_waddr%0d", i), waddr_q[i], i);
        end
        tick(3);
        chk("r1_done_once", done_cnt, 1);
        chk("r1_idle", int'(busy), 0);

        // Run 2: backpressure, ignored start pulses, product wrap
        load(-128, -1, -128);
        clear_mon();
        y_ready = 1'b0;
        pulse_start();
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 50 && !y_valid; k++) tick(1);
        chk("r2_yvalid_seen", int'(y_valid), 1);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("r2_hold_v", int'(y_valid), 1);
            chk("r2_hold_y", int'($signed(y_data)), 512);
            chk("r2_hold_clr", int'(mac_clr), 0);
        end
        start   = 1'b0;
        y_ready = 1'b1;
        tick(1);
        chk("r2_acc_clr", int'(mac_clr), 1);
        chk("r2_acc_v", int'(y_valid), 0);
        wait_done(100);
        tick(3);
        chk("r2_ny", ys.size(), 2);
        chk("r2_y0", ys[0], 512);
        chk("r2_y1_wrap", ys[1], 0);
        chk("r2_done_once", done_cnt, 1);

        // Run 3: positive wrap to negative
        load(127, 127, -128);
        clear_mon();
        pulse_start();
        wait_done(100);
        chk("r3_y0", ys[0], E_R3_Y0);
        chk("r3_y1", ys[1], 512);

        // Run 4: reset in the middle of neuron 1, then clean restart
        for (int i = 0; i < N_IN; i++) begin
            xm[i]        = DW'(i + 1);
            wm[i]        = 8'sd1;
            wm[N_IN + i] = -8'sd1;
        end
        clear_mon();
        pulse_start();
        for (int k = 0; k < 50 && ys.size() == 0; k++) tick(1);
        tick(2);
        chk("r4_feed_xaddr", int'(x_addr), 1);
        chk("r4_feed_waddr", int'(w_addr), 5);
        reset = 1'b0;
        #1;
        chk("r4_busy", int'(busy), 0);
        chk("r4_yvalid", int'(y_valid), 0);
        chk("r4_ydata", int'(y_data), 0);
        chk("r4_yaddr", int'(y_addr), 0);
        chk("r4_xaddr", int'(x_addr), 0);
        chk("r4_waddr", int'(w_addr), 0);
        chk("r4_mac_a", int'(mac_a), 0);
        chk("r4_macclr", int'(mac_clr), 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        clear_mon();
        pulse_start();
        wait_done(100);
        chk("r4_waddr0", waddr_q[0], 0);
        chk("r4_ny", ys.size(), 2);
        chk("r4_y0", ys[0], 10);
        chk("r4_a0", yas[0], 0);
        chk("r4_y1", ys[1], E_R1_Y1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
